instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Per-core instruction fetch stage driving one read port of the combinational program memory.
//  Holds a fetch PC, reads one instruction per cycle into a small prefetch FIFO,
//  and presents instructions in order to the decoder over a valid/ready handshake.
//  Supports start, branch redirect (flush) and stop (drain then idle).
// PARAMETERS
//  PROGRAM_MEM_ADDR_BITS  8   program address / PC width
//  PROGRAM_MEM_DATA_BITS  16  instruction width
//  QUEUE_DEPTH            4   prefetch FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  reset_n      in   1     asynchronous, active-low reset
//  start        in   1     pulse: begin fetching at start_pc; honoured only in IDLE
//  start_pc     in   AB    first PC after start
//  redirect     in   1     pulse: flush queue, resume fetch at redirect_pc; honoured only in FETCH
//  redirect_pc  in   AB    branch target
//  stop         in   1     pulse: cease fetching; queue drains; honoured only in FETCH
//  pmem_addr    out  AB    program memory read address (= fetch_pc register)
//  pmem_data    in   DB    program memory data for pmem_addr, valid in the same cycle
//  instr_valid  out  1     head entry valid
//  instr_ready  in   1     decoder accepts head this cycle
//  instr_data   out  DB    head instruction
//  instr_pc     out  AB    PC of head instruction
//  busy         out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, fetch_pc=0, pmem_addr=0, queue empty, instr_valid=0, instr_data=0, instr_pc=0, busy=0.
//  States: IDLE -start-> FETCH; FETCH -stop-> DRAIN; FETCH -redirect-> FETCH (flushed);
//   DRAIN -(queue empty, incl. last pop this cycle)-> IDLE.
//  IDLE: start loads fetch_pc<=start_pc, state<=FETCH. redirect/stop ignored.
//  FETCH, each cycle, no redirect: if (count<DEPTH) or (pop this cycle) push {fetch_pc, pmem_data}
//   and fetch_pc<=fetch_pc+1 (mod 2^AB, 0xFF wraps to 0x00). Otherwise fetch_pc holds.
//  pop = instr_valid & instr_ready; head advances; simultaneous push+pop on full is legal, count unchanged.
//  redirect (FETCH): priority over push and pop; queue emptied, fetch_pc<=redirect_pc,
//   instr_valid=0 next cycle; the pop handshake of that same cycle is discarded (decoder treats
//   the branch as resolved). First target instruction valid 2 cycles after redirect.
//  stop (FETCH): no push that cycle or after; pop continues; state<=DRAIN (or IDLE if empty after pop).
//  stop+redirect same cycle: redirect wins, stop ignored.
//  Latency: start at cycle T -> pmem_addr=start_pc at T+1 -> instr_valid at T+2.
//  instr_valid, instr_data, instr_pc come from the head register, never combinationally from pmem_data.
//  Steady state: one instruction per cycle when decoder always ready.
//  Count width clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH.
//  reset_n low mid-operation: immediate return to reset values regardless of state.
// STRUCTURE
//  Shared package gpu_pkg: fetch_state_t enum {IDLE, FETCH, DRAIN}; fetch_entry_t struct {pc, instr}.
//  One sub-module: sync_fifo (parameterised width/depth, push/pop/flush, full/empty/count);
//   instr_fetch_queue holds FSM and fetch_pc only.
// TESTING
//  1 Reset: assert reset_n=0 mid-FETCH with 3 entries -> all outputs 0, busy=0 asynchronously.
//  2 Streaming: mem[i]=0x1000+i, start_pc=0x10, ready=1 -> valid at T+2, pcs 0x10,0x11,.. data 0x1010,.. one/cycle.
//  3 Backpressure: ready=0 for 8 cycles -> count saturates at 4, pmem_addr frozen at 0x14; release -> no loss/dup.
//  4 Redirect: redirect_pc=0x40 while ready=1 -> valid=0 next cycle, next instr pc=0x40 data=mem[0x40].
//  5 Wrap: start_pc=0xFE -> pcs 0xFE,0xFF,0x00,0x01 in order.
//  6 Stop: stop with 2 entries queued -> both delivered, then busy=0; stop+redirect same cycle -> redirect taken.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types for the instruction fetch path: fetch FSM states and the
// {pc, instr} entry carried through the prefetch queue.
package gpu_pkg;

  localparam int unsigned PMEM_ADDR_BITS = 8;
  localparam int unsigned PMEM_DATA_BITS = 16;
  localparam int unsigned FETCH_QUEUE_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PMEM_ADDR_BITS-1:0] pc;
    logic [PMEM_DATA_BITS-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with flush.
// Flush has priority over push/pop; push on full is accepted only together with a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign pop_ok_s  = pop_i & ~empty_o & ~flush_i;
  assign push_ok_s = push_i & (~full_o | pop_ok_s) & ~flush_i;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC and the IDLE/FETCH/DRAIN control,
// reading one instruction per cycle from program memory into a prefetch FIFO.
module instr_fetch_queue
  import gpu_pkg::*;
#(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = PMEM_ADDR_BITS,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = PMEM_DATA_BITS,
  parameter int unsigned QUEUE_DEPTH           = FETCH_QUEUE_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] start_pc,
  input  logic                             redirect,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] redirect_pc,
  input  logic                             stop,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] pmem_addr,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] pmem_data,
  output logic                             instr_valid,
  input  logic                             instr_ready,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instr_data,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] instr_pc,
  output logic                             busy
);

  localparam int unsigned AB = PROGRAM_MEM_ADDR_BITS;
  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [AB-1:0] fetch_pc_q, fetch_pc_d;
  logic          push_s;
  logic          pop_s;
  logic          flush_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;
  logic          last_out_s;
  fetch_entry_t  wentry_s;
  fetch_entry_t  head_s;

  // A redirect discards the decoder handshake of the same cycle.
  assign flush_s    = (state_q == FETCH) & redirect;
  assign pop_s      = ~empty_s & instr_ready & ~flush_s;
  assign last_out_s = empty_s | ((count_s == CW'(1)) & pop_s);

  assign wentry_s.pc    = fetch_pc_q;
  assign wentry_s.instr = pmem_data;

  // FSM next-state, fetch PC advance and queue push decision
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          fetch_pc_d = start_pc;
          state_d    = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (stop) begin
          state_d = last_out_s ? IDLE : DRAIN;
        end else if (~full_s | pop_s) begin
          push_s     = 1'b1;
          fetch_pc_d = fetch_pc_q + AB'(1);
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
      end
      DRAIN: begin
        if (last_out_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and fetch PC registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .wdata_i (wentry_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  assign pmem_addr   = fetch_pc_q;
  assign instr_valid = ~empty_s;
  assign instr_data  = head_s.instr;
  assign instr_pc    = head_s.pc;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming, backpressure, redirect,
// stop/drain, PC wrap and asynchronous reset, against a mem[i]=0x1000+i program.
module tb_instr_fetch_queue;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  start_pc;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        stop;
  logic [7:0]  pmem_addr;
  logic [15:0] pmem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [7:0]  instr_pc;
  logic        busy;

  int n_checks;
  int n_fail;

  instr_fetch_queue dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .start_pc    (start_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stop        (stop),
    .pmem_addr   (pmem_addr),
    .pmem_data   (pmem_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .busy        (busy)
  );

  // Combinational program memory: mem[i] = 0x1000 + i
  assign pmem_data = 16'h1000 + {8'h00, pmem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [7:0] pc, input logic [15:0] data);
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check_eq({tag, "_pc"}, 32'(instr_pc), 32'(pc));
    check_eq({tag, "_data"}, 32'(instr_data), 32'(data));
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check_eq({tag, "_data"}, 32'(instr_data), 32'd0);
    check_eq({tag, "_pc"}, 32'(instr_pc), 32'd0);
    check_eq({tag, "_addr"}, 32'(pmem_addr), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    start_pc    = 8'h00;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    stop        = 1'b0;
    instr_ready = 1'b0;
    repeat (2) tick();
    check_idle_zero("reset");
    reset_n = 1'b1;
    tick();

    // Start at 0x10 with decoder stalled: latency, then queue fills to 4
    start    = 1'b1;
    start_pc = 8'h10;
    tick();
    start = 1'b0;
    check_eq("start_addr", 32'(pmem_addr), 32'h10);
    check_eq("start_valid_t1", 32'(instr_valid), 32'd0);
    check_eq("start_busy", 32'(busy), 32'd1);
    tick();
    check_head("start_t2", 8'h10, 16'h1010);
    repeat (6) tick();
    check_eq("bp_addr_frozen", 32'(pmem_addr), 32'h14);
    check_head("bp_head", 8'h10, 16'h1010);

    // Release: one instruction per cycle, no loss or duplication
    instr_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_head("stream", 8'(8'h10 + k), 16'(16'h1010 + k));
    end

    // Redirect to 0x40 while the decoder is accepting
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    check_eq("redir_valid", 32'(instr_valid), 32'd0);
    check_eq("redir_addr", 32'(pmem_addr), 32'h40);
    tick();
    check_head("redir_t2", 8'h40, 16'h1040);
    tick();
    check_head("redir_t3", 8'h41, 16'h1041);

    // Stop and redirect together: redirect wins
    stop        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 8'h80;
    tick();
    stop     = 1'b0;
    redirect = 1'b0;
    check_eq("sr_valid", 32'(instr_valid), 32'd0);
    check_eq("sr_busy", 32'(busy), 32'd1);
    tick();
    check_head("sr_head", 8'h80, 16'h1080);

    // Stop with two entries queued: both delivered, then idle
    instr_ready = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("stop_busy", 32'(busy), 32'd1);
    check_eq("stop_addr", 32'(pmem_addr), 32'h82);
    check_head("stop_head0", 8'h80, 16'h1080);
    instr_ready = 1'b1;
    tick();
    check_head("stop_head1", 8'h81, 16'h1081);
    check_eq("drain_busy", 32'(busy), 32'd1);
    tick();
    check_eq("drained_valid", 32'(instr_valid), 32'd0);
    check_eq("drained_busy", 32'(busy), 32'd0);

    // Redirect while idle is ignored
    redirect    = 1'b1;
    redirect_pc = 8'h33;
    tick();
    redirect = 1'b0;
    check_eq("idle_redir_busy", 32'(busy), 32'd0);
    check_eq("idle_redir_addr", 32'(pmem_addr), 32'h82);

    // PC wrap from 0xFE
    start    = 1'b1;
    start_pc = 8'hFE;
    tick();
    start = 1'b0;
    check_eq("wrap_addr", 32'(pmem_addr), 32'hFE);
    tick();
    check_head("wrap0", 8'hFE, 16'h10FE);
    tick();
    check_head("wrap1", 8'hFF, 16'h10FF);
    tick();
    check_head("wrap2", 8'h00, 16'h1000);
    tick();
    check_head("wrap3", 8'h01, 16'h1001);

    // Asynchronous reset with three entries queued
    instr_ready = 1'b0;
    repeat (2) tick();
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_zero("async_rst");
    tick();
    reset_n = 1'b1;
    tick();
    check_idle_zero("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
